// File: rtl/dac_wave_gen_pkg.sv
// Shared encodings and waveform shaping for the dac_wave_gen slice.
package dac_wave_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'b00,
    WAVE_TRI  = 2'b01,
    WAVE_SQR  = 2'b10,
    WAVE_SINE = 2'b11
  } wave_t;

  localparam logic [7:0] MIDSCALE = 8'h80;

  // Sine code arrives precomputed so the shaper stays free of table logic.
  function automatic logic [7:0] wave_shape(input wave_t sel, input logic [7:0] p,
                                            input logic [7:0] sine);
    logic [7:0] result;
    case (sel)
      WAVE_SAW: result = p;
      WAVE_TRI: result = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      WAVE_SQR: result = p[7] ? 8'h00 : 8'hFF;
      default:  result = sine;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dac_sine_rom.sv
// Combinational 8-bit sine lookup built from a 64-entry quarter-wave table.
module dac_sine_rom
  import dac_wave_gen_pkg::*;
(
  input  logic [7:0] phase,
  output logic [7:0] sine
);

  localparam logic [7:0] QUARTER [64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
    8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
  };

  logic [5:0] idx;
  logic [5:0] mirror;

  assign idx    = phase[5:0];
  assign mirror = 6'd0 - idx;

  // Quadrant starts (0x40, 0x80, 0xC0) fall outside the table; 0x80 keeps round-half-up.
  always_comb begin
    sine = QUARTER[idx];
    case (phase[7:6])
      2'd0: sine = QUARTER[idx];
      2'd1: sine = (idx == 6'd0) ? 8'hFF : QUARTER[mirror];
      2'd2: sine = (idx == 6'd0) ? MIDSCALE : ~QUARTER[idx];
      default: sine = (idx == 6'd0) ? 8'h00 : ~QUARTER[mirror];
    endcase
  end

endmodule

// File: rtl/dac_wave_gen.sv
// Waveform sample generator feeding a TLC5620 serializer over a valid/ready handshake.
// Define DAC_WAVE_SINE_EN to build the sine table; otherwise wave_sel=11 gives midscale.
module dac_wave_gen
  import dac_wave_gen_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [1:0]  wave_sel,
  input  logic [15:0] step,
  input  logic [15:0] rate_div,
  input  logic [1:0]  dac_chan,
  input  logic        dac_rng,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [7:0]  smp_data,
  output logic [1:0]  smp_addr,
  output logic        smp_rng,
  output logic        ovf_sticky,
  output logic [7:0]  led
);

  state_t      state, next_state;
  logic [15:0] tick_cnt, rate_q, phase;
  logic        tick, transfer;
  logic        load_sample, drop_sample, clear_valid, go_idle;
  logic [7:0]  sine_val, wave_val;

  assign tick     = (tick_cnt == rate_q);
  assign transfer = smp_valid & smp_ready;

`ifdef DAC_WAVE_SINE_EN
  dac_sine_rom u_sine_rom (
    .phase (phase[15:8]),
    .sine  (sine_val)
  );
`else
  assign sine_val = MIDSCALE;
`endif

  assign wave_val = wave_shape(wave_t'(wave_sel), phase[15:8], sine_val);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (enable) next_state = ST_RUN;
      ST_RUN: begin
        if (!enable)   next_state = ST_IDLE;
        else if (tick) next_state = ST_PEND;
      end
      ST_PEND: begin
        if (transfer) begin
          if (!enable)    next_state = ST_IDLE;
          else if (!tick) next_state = ST_RUN;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A tick while a sample is still unaccepted is a drop, unless the handshake frees the slot.
  always_comb begin
    load_sample = 1'b0;
    drop_sample = 1'b0;
    clear_valid = 1'b0;
    go_idle     = (next_state == ST_IDLE);
    case (state)
      ST_RUN: load_sample = enable & tick;
      ST_PEND: begin
        if (transfer) begin
          load_sample = enable & tick;
          clear_valid = ~(enable & tick);
        end else begin
          drop_sample = tick;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt   <= '0;
      rate_q     <= '0;
      phase      <= '0;
      ovf_sticky <= 1'b0;
      led        <= '0;
      smp_valid  <= 1'b0;
      smp_data   <= '0;
      smp_addr   <= '0;
      smp_rng    <= 1'b0;
    end else begin
      if (go_idle || state == ST_IDLE) begin
        tick_cnt <= '0;
        rate_q   <= rate_div;
        phase    <= '0;
      end else begin
        if (tick) begin
          tick_cnt <= '0;
          rate_q   <= rate_div;
        end else begin
          tick_cnt <= tick_cnt + 16'd1;
        end
        if (load_sample || drop_sample) phase <= phase + step;
      end

      if (go_idle)          ovf_sticky <= 1'b0;
      else if (drop_sample) ovf_sticky <= 1'b1;

      if (transfer) led <= smp_data;

      if (load_sample) begin
        smp_valid <= 1'b1;
        smp_data  <= wave_val;
        smp_addr  <= dac_chan;
        smp_rng   <= dac_rng;
      end else if (clear_valid || go_idle) begin
        smp_valid <= 1'b0;
      end
    end
  end

endmodule
